// File: rtl/bpu_gshare.sv
// Fetch-stage branch predictor: a tagged direct-mapped BTB plus a 2-bit PHT, with a registered response.
// Define BPU_GSHARE_EN to XOR the speculative GHR into the PHT index; leave it undefined for bimodal indexing.

module bpu_gshare_slot #(
  parameter int TAG_W = 22
) (
  input  logic             live,
  input  logic             vld,
  input  logic             is_cond,
  input  logic [TAG_W-1:0] ent_tag,
  input  logic [TAG_W-1:0] tag,
  input  logic [1:0]       ctr,
  output logic             hit
);
  assign hit = live & vld & (ent_tag == tag) & (~is_cond | ctr[1]);
endmodule

module bpu_gshare #(
  parameter int FETCH_W = 4,
  parameter int IDX_W   = 8,
  parameter int GHR_W   = 8,
  parameter int UPD_N   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [31:0]                   req_pc,
  input  logic                          hold,
  input  logic                          flush,
  output logic                          pred_valid,
  output logic [FETCH_W-1:0]            pred_mask,
  output logic [FETCH_W-1:0]            pred_taken,
  output logic [31:0]                   pred_next_pc,
  output logic [GHR_W-1:0]              pred_ghr,
  input  logic [UPD_N-1:0]              upd_valid,
  input  logic [UPD_N-1:0]              upd_taken,
  input  logic [UPD_N-1:0]              upd_is_cond,
  input  logic [UPD_N-1:0]              upd_mispredict,
  input  logic [UPD_N-1:0][31:0]        upd_pc,
  input  logic [UPD_N-1:0][31:0]        upd_target,
  input  logic [UPD_N-1:0][GHR_W-1:0]   upd_ghr
);
  localparam int LW    = $clog2(FETCH_W);
  localparam int ENT   = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [29:0]      tgt;
    logic             cond;
  } btb_ent_t;

  btb_ent_t   btb [ENT];
  logic [1:0] pht [ENT];

  logic [GHR_W-1:0] ghr_hist;
  logic [UPD_N-1:0] mp_vec;
  logic             mp;

  assign mp_vec = upd_valid & upd_mispredict;
  assign mp     = |mp_vec;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr, ghr_fix;
  logic             acc;

  assign ghr_hist = ghr;
  assign acc      = req_valid & ~hold & ~flush & ~mp;

  // Lowest mispredicting lane is the oldest branch, so its history wins.
  always_comb begin
    ghr_fix = '0;
    for (int k = UPD_N - 1; k >= 0; k--)
      if (mp_vec[k]) ghr_fix = (upd_ghr[k] << 1) | GHR_W'(upd_taken[k]);
  end
`else
  assign ghr_hist = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{req_pc[1:0], upd_pc, upd_target, upd_ghr};

  // ---- lookup ----
  logic [FETCH_W-1:0]            live, hit, win, mask_c;
  logic [FETCH_W-1:0][29:0]      slot_tgt;
  logic [FETCH_W-1:0][IDX_W-1:0] s_bidx, s_pidx;
  logic [FETCH_W-1:0][TAG_W-1:0] s_tag;
  logic [31:0]                   next_c;

  for (genvar s = 0; s < FETCH_W; s++) begin : g_slot
    logic [31:0] spc;
    assign spc         = {req_pc[31:2+LW], LW'(s), 2'b00};
    assign s_bidx[s]   = spc[2+:IDX_W];
    assign s_tag[s]    = spc[31:2+IDX_W];
    assign s_pidx[s]   = spc[2+:IDX_W] ^ IDX_W'(ghr_hist);
    assign live[s]     = LW'(s) >= req_pc[2+:LW];
    assign slot_tgt[s] = btb[s_bidx[s]].tgt;

    bpu_gshare_slot #(.TAG_W(TAG_W)) u_slot (
      .live    (live[s]),
      .vld     (btb[s_bidx[s]].vld),
      .is_cond (btb[s_bidx[s]].cond),
      .ent_tag (btb[s_bidx[s]].tag),
      .tag     (s_tag[s]),
      .ctr     (pht[s_pidx[s]]),
      .hit     (hit[s])
    );
  end

  assign win    = hit & (~hit + FETCH_W'(1));
  assign mask_c = (|win) ? (live & ((win << 1) - FETCH_W'(1))) : live;

  always_comb begin
    next_c = {req_pc[31:2+LW], {(2+LW){1'b0}}} + 32'(4 * FETCH_W);
    for (int s = 0; s < FETCH_W; s++)
      if (win[s]) next_c = {slot_tgt[s], 2'b00};
  end

  // ---- update lanes: taken always (re)writes the BTB entry ----
  logic [UPD_N-1:0][IDX_W-1:0] u_bidx, u_pidx;
  logic [UPD_N-1:0]            btb_we, pht_we;
  logic [UPD_N-1:0][1:0]       pht_wd;
  btb_ent_t                    btb_wd [UPD_N];

  for (genvar k = 0; k < UPD_N; k++) begin : g_lane
    logic [TAG_W-1:0] utag;
    logic             uhit;
    logic [1:0]       ctr;
    assign u_bidx[k] = upd_pc[k][2+:IDX_W];
    assign utag      = upd_pc[k][31:2+IDX_W];
`ifdef BPU_GSHARE_EN
    assign u_pidx[k] = u_bidx[k] ^ IDX_W'(upd_ghr[k]);
`else
    assign u_pidx[k] = u_bidx[k];
`endif
    assign uhit      = btb[u_bidx[k]].vld & (btb[u_bidx[k]].tag == utag);
    assign ctr       = pht[u_pidx[k]];
    assign btb_we[k] = upd_valid[k] & upd_taken[k];
    assign btb_wd[k] = '{vld: 1'b1, tag: utag, tgt: upd_target[k][31:2], cond: upd_is_cond[k]};
    assign pht_we[k] = upd_valid[k] & ((upd_taken[k] & ~uhit) | (uhit & upd_is_cond[k]));
    assign pht_wd[k] = ~uhit        ? 2'd2 :
                       upd_taken[k] ? ((ctr == 2'd3) ? ctr : ctr + 2'd1) :
                                      ((ctr == 2'd0) ? ctr : ctr - 2'd1);
  end

  // Later lanes overwrite earlier ones on an index collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENT; i++) begin
        btb[i] <= '0;
        pht[i] <= 2'd1;
      end
    end else begin
      for (int k = 0; k < UPD_N; k++) begin
        if (btb_we[k]) btb[u_bidx[k]] <= btb_wd[k];
        if (pht_we[k]) pht[u_pidx[k]] <= pht_wd[k];
      end
    end
  end

`ifdef BPU_GSHARE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ghr <= '0;
    else if (mp)  ghr <= ghr_fix;
    else if (acc) ghr <= (ghr << 1) | GHR_W'(|win);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid   <= 1'b0;
      pred_mask    <= '0;
      pred_taken   <= '0;
      pred_next_pc <= '0;
      pred_ghr     <= '0;
    end else if (mp || flush) begin
      pred_valid <= 1'b0;
    end else if (!hold) begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_mask    <= mask_c;
        pred_taken   <= win;
        pred_next_pc <= next_c;
        pred_ghr     <= ghr_hist;
      end
    end
  end
endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: reset/cold-miss vector table, directed corner sequences, then random traffic vs a model.
module tb_bpu_gshare;
  localparam int FW = 4, IW = 8, GW = 8, UN = 2;
`ifdef BPU_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic clk, reset, req_valid, hold, flush;
  logic [31:0] req_pc;
  logic pred_valid;
  logic [FW-1:0] pred_mask, pred_taken;
  logic [31:0] pred_next_pc;
  logic [GW-1:0] pred_ghr;
  logic [UN-1:0] upd_valid, upd_taken, upd_is_cond, upd_mispredict;
  logic [UN-1:0][31:0] upd_pc, upd_target;
  logic [UN-1:0][GW-1:0] upd_ghr;

  bpu_gshare #(.FETCH_W(FW), .IDX_W(IW), .GHR_W(GW), .UPD_N(UN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc), .hold(hold), .flush(flush),
    .pred_valid(pred_valid), .pred_mask(pred_mask), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_is_cond(upd_is_cond),
    .upd_mispredict(upd_mispredict), .upd_pc(upd_pc), .upd_target(upd_target), .upd_ghr(upd_ghr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_pc = '0; hold = 0; flush = 0;
    upd_valid = '0; upd_taken = '0; upd_is_cond = '0; upd_mispredict = '0;
    upd_pc = '0; upd_target = '0; upd_ghr = '0;
  endtask

  task automatic set_upd(input int k, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit tk, input bit cond, input bit mpr, input logic [7:0] g);
    upd_valid[k] = 1'b1; upd_pc[k] = pc; upd_target[k] = tgt;
    upd_taken[k] = tk; upd_is_cond[k] = cond; upd_mispredict[k] = mpr; upd_ghr[k] = g;
  endtask

  task automatic req(input logic [31:0] pc);
    idle();
    req_valid = 1; req_pc = pc;
  endtask

  task automatic pulse_reset();
    reset = 1; #1; reset = 0;
  endtask

  // ---------------- reference model ----------------
  bit          m_vld  [256];
  logic [31:0] m_tag  [256];
  logic [31:0] m_tgt  [256];
  bit          m_cond [256];
  int          m_pht  [256];
  int          m_ghr;
  bit          e_valid;
  logic [3:0]  e_mask, e_taken;
  logic [31:0] e_next;
  int          e_ghr;

  function automatic int hist(input int g);
    return GS ? g : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cond[i] = 0; m_pht[i] = 1;
    end
    m_ghr = 0; e_valid = 0; e_mask = 0; e_taken = 0; e_next = 0; e_ghr = 0;
  endtask

  task automatic model_step();
    bit mp = 0;
    int fix = 0, off, win, last;
    logic [31:0] base, pc;
    logic [3:0] l_mask, l_taken;
    logic [31:0] l_next;
    bit          o_vld [256];
    logic [31:0] o_tag [256];
    int          o_pht [256];
    for (int k = 0; k < UN; k++)
      if (!mp && upd_valid[k] && upd_mispredict[k]) begin
        mp = 1; fix = ((int'(upd_ghr[k]) << 1) | int'(upd_taken[k])) & 255;
      end
    // lookup against the pre-update tables
    off = int'(req_pc[3:2]); base = req_pc & ~32'hF; win = -1;
    for (int s = off; s < 4; s++) begin
      int idx, pidx;
      pc = base + 32'(4 * s);
      idx = int'(pc[9:2]); pidx = idx ^ hist(m_ghr);
      if (win < 0 && m_vld[idx] && m_tag[idx] == (pc >> 10) && (!m_cond[idx] || m_pht[pidx] >= 2))
        win = s;
    end
    last = (win >= 0) ? win : 3;
    l_mask = 0; l_taken = 0;
    for (int s = off; s <= last; s++) l_mask[s] = 1'b1;
    if (win >= 0) begin
      l_taken[win] = 1'b1; l_next = m_tgt[pc_idx(base, win)];
    end else l_next = base + 32'd16;
    // updates read the snapshot, write in lane order
    o_vld = m_vld; o_tag = m_tag; o_pht = m_pht;
    for (int k = 0; k < UN; k++) if (upd_valid[k]) begin
      int idx, pidx;
      bit h;
      idx = int'(upd_pc[k][9:2]); pidx = idx ^ hist(int'(upd_ghr[k]));
      h = o_vld[idx] && o_tag[idx] == (upd_pc[k] >> 10);
      if (upd_taken[k]) begin
        m_vld[idx] = 1; m_tag[idx] = upd_pc[k] >> 10;
        m_tgt[idx] = upd_target[k] & ~32'h3; m_cond[idx] = upd_is_cond[k];
      end
      if (upd_taken[k] && !h) m_pht[pidx] = 2;
      else if (h && upd_is_cond[k])
        m_pht[pidx] = upd_taken[k] ? ((o_pht[pidx] < 3) ? o_pht[pidx] + 1 : 3)
                                   : ((o_pht[pidx] > 0) ? o_pht[pidx] - 1 : 0);
    end
    if (mp) begin
      e_valid = 0;
      if (GS) m_ghr = fix;
    end else if (flush) e_valid = 0;
    else if (!hold) begin
      if (req_valid) begin
        e_valid = 1; e_mask = l_mask; e_taken = l_taken; e_next = l_next; e_ghr = hist(m_ghr);
        m_ghr = ((m_ghr << 1) | int'(l_taken != 0)) & 255;
      end else e_valid = 0;
    end
  endtask

  function automatic int pc_idx(input logic [31:0] base, input int s);
    logic [31:0] p;
    p = base + 32'(4 * s);
    return int'(p[9:2]);
  endfunction

  function automatic logic [31:0] rnd_pc();
    return ($urandom_range(0, 1) ? 32'h2C000000 : 32'h1C000000) + 32'($urandom_range(0, 63) * 4);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  mask;
    logic [31:0] nxt;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{32'h1C000004, 4'b1110, 32'h1C000010};
    tbl[1] = '{32'h00000000, 4'b1111, 32'h00000010};
    tbl[2] = '{32'hFFFFFFFC, 4'b1000, 32'h00000000};
    tbl[3] = '{32'h1C000008, 4'b1100, 32'h1C000010};

    idle(); reset = 1;
    #12;
    chk("rst_valid", 32'(pred_valid), 0);
    chk("rst_mask", 32'(pred_mask), 0);
    chk("rst_next", pred_next_pc, 0);
    chk("rst_ghr", 32'(pred_ghr), 0);
    reset = 0;
    cyc();

    // cold misses, empty BTB
    foreach (tbl[i]) begin
      req(tbl[i].pc); cyc();
      chk("cold_valid", 32'(pred_valid), 1);
      chk("cold_mask", 32'(pred_mask), 32'(tbl[i].mask));
      chk("cold_taken", 32'(pred_taken), 0);
      chk("cold_next", pred_next_pc, tbl[i].nxt);
      chk("cold_ghr", 32'(pred_ghr), 0);
    end

    // allocate then hit
    idle(); set_upd(0, 32'h1C000008, 32'h1C000100, 1, 1, 0, 8'h00); cyc();
    chk("idle_valid", 32'(pred_valid), 0);
    req(32'h1C000000); cyc();
    chk("hit_taken", 32'(pred_taken), 32'b0100);
    chk("hit_mask", 32'(pred_mask), 32'b0111);
    chk("hit_next", pred_next_pc, 32'h1C000100);
    req(32'h1C000040); cyc();
    chk("ghr_shift1", 32'(pred_ghr), GS ? 1 : 0);

    // counter saturation both ways
    idle(); pulse_reset();
    set_upd(0, 32'h1C000008, 32'h1C000100, 1, 1, 0, 8'h00); cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); set_upd(0, 32'h1C000008, 32'h1C000100, 0, 1, 0, 8'h00); cyc();
    end
    req(32'h1C000000); cyc();
    chk("sat0_taken", 32'(pred_taken), 0);
    chk("sat0_next", pred_next_pc, 32'h1C000010);
    for (int i = 0; i < 4; i++) begin
      idle(); set_upd(0, 32'h1C000008, 32'h1C000100, 1, 1, 0, 8'h00); cyc();
    end
    idle(); set_upd(0, 32'h1C000008, 32'h1C000100, 0, 1, 0, 8'h00); cyc();
    req(32'h1C000000); cyc();
    chk("sat3_taken", 32'(pred_taken), 32'b0100);
    chk("sat3_next", pred_next_pc, 32'h1C000100);

    // dual-lane collision on one BTB index
    idle();
    set_upd(0, 32'h1C000020, 32'h000000A0, 1, 0, 0, 8'h00);
    set_upd(1, 32'h1C000020, 32'h000000B0, 1, 0, 0, 8'h00);
    cyc();
    req(32'h1C000020); cyc();
    chk("coll_next", pred_next_pc, 32'h000000B0);
    chk("coll_taken", 32'(pred_taken), 32'b0001);
    chk("coll_mask", 32'(pred_mask), 32'b0001);

    // mispredict: lowest lane restores, beats a same-cycle request
    idle();
    set_upd(0, 32'h3C000200, 32'h3C001000, 1, 1, 1, 8'h07);
    set_upd(1, 32'h3C000300, 32'h3C002000, 1, 1, 1, 8'h55);
    cyc();
    chk("mp_valid0", 32'(pred_valid), 0);
    req(32'h1C000040); cyc();
    chk("mp_lane0_ghr", 32'(pred_ghr), GS ? 32'h0F : 0);
    req(32'h1C000040);
    set_upd(0, 32'h3C000400, 32'h0, 0, 1, 0, 8'h00);
    set_upd(1, 32'h3C000380, 32'h3C003000, 1, 1, 1, 8'h33);
    cyc();
    chk("mp_kill", 32'(pred_valid), 0);
    req(32'h1C000040); cyc();
    chk("mp_valid1", 32'(pred_valid), 1);
    chk("mp_ghr", 32'(pred_ghr), GS ? 32'h67 : 0);

    // hold three cycles, then flush+hold
    req(32'h1C000008); hold = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_valid", 32'(pred_valid), 1);
      chk("hold_mask", 32'(pred_mask), 32'b1111);
      chk("hold_next", pred_next_pc, 32'h1C000050);
      chk("hold_ghr", 32'(pred_ghr), GS ? 32'h67 : 0);
    end
    flush = 1; cyc();
    chk("flush_valid", 32'(pred_valid), 0);
    req(32'h1C000040); cyc();
    chk("flush_ghr", 32'(pred_ghr), GS ? 32'hCE : 0);

    // async reset between edges
    reset = 1; #1;
    chk("arst_valid", 32'(pred_valid), 0);
    chk("arst_next", pred_next_pc, 0);
    chk("arst_mask", 32'(pred_mask), 0);
    reset = 0;

    // random traffic against the model
    idle(); pulse_reset(); model_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      req_valid = ($urandom_range(0, 3) != 0);
      req_pc    = rnd_pc() + 32'($urandom_range(0, 3));
      hold      = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < UN; k++) if ($urandom_range(0, 1) == 1)
        set_upd(k, rnd_pc(), $urandom(), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1 ? 8'(m_ghr) : 8'($urandom));
      model_step();
      cyc();
      chk("rnd_valid", 32'(pred_valid), 32'(e_valid));
      if (e_valid) begin
        chk("rnd_mask", 32'(pred_mask), 32'(e_mask));
        chk("rnd_taken", 32'(pred_taken), 32'(e_taken));
        chk("rnd_next", pred_next_pc, e_next);
        chk("rnd_ghr", 32'(pred_ghr), 32'(e_ghr));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
